// File: rtl/main_pkg.sv
// Shared definitions for the stack calculator: opcode map and default depth.
package main_pkg;

  localparam int DEPTH_DEFAULT = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_POP  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_MOD  = 4'd6;
  localparam logic [3:0] OP_PUSH = 4'd7;
  localparam logic [3:0] OP_DUP  = 4'd8;
  localparam logic [3:0] OP_SWAP = 4'd9;

  // True for the opcodes that consume two entries and push one result.
  function automatic logic is_binary(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOD);
  endfunction

endpackage

// File: rtl/main_stack_alu.sv
// Combinational unsigned ALU for the stack calculator; a = second entry, b = top.
module stack_alu
  import main_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic [W-1:0] result,
  output logic         div_by_zero
);

  logic b_zero;
  assign b_zero = (b == '0);

  // Select the arithmetic result; division by zero yields 0 and is flagged.
  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_MUL: result = a * b;
      OP_DIV: begin
        div_by_zero = b_zero;
        result      = b_zero ? '0 : a / b;
      end
      OP_MOD: begin
        div_by_zero = b_zero;
        result      = b_zero ? '0 : a % b;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/main.sv
// Integer stack calculator: register-array stack, entry count and sticky error flag.
module main
  import main_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic [3:0]   op,
  input  logic         apply,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          valid_q;
  logic          err_d;

  logic [AW-1:0] top_idx, sec_idx, new_idx;
  logic [W-1:0]  top_val, sec_val;
  logic [W-1:0]  alu_res;
  logic          alu_dbz;
  logic          has1, has2, full;

  // Entry count is at most DEPTH, so its low AW bits address the array directly.
  assign top_idx = AW'(count_q - CW'(1));
  assign sec_idx = AW'(count_q - CW'(2));
  assign new_idx = AW'(count_q);
  assign top_val = mem_q[top_idx];
  assign sec_val = mem_q[sec_idx];

  assign has1 = (count_q >= CW'(1));
  assign has2 = (count_q >= CW'(2));
  assign full = (count_q == CW'(DEPTH));

  stack_alu #(.W(W)) u_alu (
    .a           (sec_val),
    .b           (top_val),
    .op          (op),
    .result      (alu_res),
    .div_by_zero (alu_dbz)
  );

  // Decide whether the requested op is legal and what the new entry count is.
  always_comb begin
    err_d   = 1'b0;
    count_d = count_q;
    case (op)
      OP_POP: begin
        err_d   = !has1;
        count_d = count_q - CW'(1);
      end
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
        err_d   = !has2 || alu_dbz;
        count_d = count_q - CW'(1);
      end
      OP_PUSH: begin
        err_d   = full;
        count_d = count_q + CW'(1);
      end
      OP_DUP: begin
        err_d   = !has1 || full;
        count_d = count_q + CW'(1);
      end
      OP_SWAP: err_d = !has2;
      default: count_d = count_q;
    endcase
  end

  // Control state: count and sticky valid; an erroring op leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      valid_q <= 1'b1;
    end else if (apply) begin
      if (err_d) begin
        valid_q <= 1'b0;
      end else begin
        count_q <= count_d;
      end
    end
  end

  // Storage writes; contents are not reset, the count alone defines what is live.
  always_ff @(posedge clk) begin
    if (apply && !err_d) begin
      if (is_binary(op)) begin
        mem_q[sec_idx] <= alu_res;
      end else if (op == OP_PUSH) begin
        mem_q[new_idx] <= in;
      end else if (op == OP_DUP) begin
        mem_q[new_idx] <= top_val;
      end else if (op == OP_SWAP) begin
        mem_q[top_idx] <= sec_val;
        mem_q[sec_idx] <= top_val;
      end
    end
  end

  assign head  = has1 ? top_val : '0;
  assign empty = (count_q == '0);
  assign valid = valid_q;

endmodule

// File: tb/tb_main.sv
// Randomized self-checking bench for the stack calculator with a queue-based model.
module tb_main;
  import main_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in;
  logic [3:0]   op;
  logic         apply;
  logic [W-1:0] head;
  logic         empty;
  logic         valid;

  always #5 clk = ~clk;

  main #(.W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .op    (op),
    .apply (apply),
    .head  (head),
    .empty (empty),
    .valid (valid)
  );

  int n_cmp = 0;
  int n_mis = 0;

  longint unsigned mq[$];
  bit              mv;
  localparam longint unsigned MOD_W = 64'd1 << W;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour written from the opcode rules with a queue (back = top).
  function automatic void model_step(input logic [3:0] o, input logic [W-1:0] v);
    longint unsigned a, b, r;
    bit err = 0;
    int n = mq.size();
    case (o)
      4'd1: if (n < 1) err = 1; else void'(mq.pop_back());
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        if (n < 2) err = 1;
        else begin
          a = mq[n-2];
          b = mq[n-1];
          if ((o == 4'd5 || o == 4'd6) && b == 0) err = 1;
          else begin
            case (o)
              4'd2: r = (a + b) % MOD_W;
              4'd3: r = (a + MOD_W - b) % MOD_W;
              4'd4: r = (a * b) % MOD_W;
              4'd5: r = a / b;
              default: r = a % b;
            endcase
            void'(mq.pop_back());
            void'(mq.pop_back());
            mq.push_back(r);
          end
        end
      end
      4'd7: if (n == DEPTH) err = 1; else mq.push_back(longint'(v));
      4'd8: if (n < 1 || n == DEPTH) err = 1; else mq.push_back(mq[n-1]);
      4'd9: begin
        if (n < 2) err = 1;
        else begin
          a = mq[n-1];
          mq[n-1] = mq[n-2];
          mq[n-2] = a;
        end
      end
      default: ;
    endcase
    if (err) mv = 0;
  endfunction

  task automatic check_outs(input string tag);
    logic [31:0] eh;
    eh = (mq.size() != 0) ? 32'(mq[mq.size()-1]) : 32'd0;
    chk({tag, "/head"}, 32'(head), eh);
    chk({tag, "/empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, "/valid"}, 32'(valid), 32'(mv));
  endtask

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] v);
    @(negedge clk);
    op = o; in = v; apply = 1'b1;
    @(posedge clk);
    #1;
    apply = 1'b0;
    model_step(o, v);
    check_outs("op");
  endtask

  task automatic idle(input logic [3:0] o, input logic [W-1:0] v);
    @(negedge clk);
    op = o; in = v; apply = 1'b0;
    @(posedge clk);
    #1;
    check_outs("idle");
  endtask

  task automatic do_reset(input bit with_apply);
    @(negedge clk);
    rst = 1'b1; apply = with_apply; op = OP_PUSH; in = W'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0; apply = 1'b0;
    mq.delete();
    mv = 1;
    check_outs("reset");
  endtask

  initial begin
    int r;
    rst = 1'b1; apply = 1'b0; op = '0; in = '0;
    mq.delete();
    mv = 1;
    repeat (2) @(posedge clk);

    // Divide by zero
    do_reset(0);
    do_op(OP_PUSH, 16'd150);
    do_op(OP_PUSH, 16'd0);
    chk("div0/head_pre", 32'(head), 32'd0);
    chk("div0/empty_pre", 32'(empty), 32'd0);
    do_op(OP_DIV, 16'd0);
    chk("div0/valid", 32'(valid), 32'd0);
    chk("div0/head", 32'(head), 32'd0);
    do_op(OP_POP, 16'd0);
    chk("div0/head_after_pop", 32'(head), 32'd150);
    do_op(OP_POP, 16'd0);
    chk("div0/empty_after_2pop", 32'(empty), 32'd1);

    // Subtract and wrap
    do_reset(0);
    do_op(OP_PUSH, 16'd7);
    do_op(OP_PUSH, 16'd5);
    do_op(OP_SUB, 16'd0);
    chk("sub/head", 32'(head), 32'd2);
    chk("sub/valid", 32'(valid), 32'd1);
    do_op(OP_PUSH, 16'd9);
    do_op(OP_SUB, 16'd0);
    chk("subwrap/head", 32'(head), 32'd65529);

    // Multiply truncation and modulo
    do_reset(0);
    do_op(OP_PUSH, 16'd300);
    do_op(OP_PUSH, 16'd300);
    do_op(OP_MUL, 16'd0);
    chk("mul/head", 32'(head), 32'd24464);
    do_op(OP_PUSH, 16'd7);
    do_op(OP_MOD, 16'd0);
    chk("mod/head", 32'(head), 32'd6);

    // Underflow, sticky error, reset recovery
    do_reset(0);
    do_op(OP_POP, 16'd0);
    chk("under/valid", 32'(valid), 32'd0);
    chk("under/empty", 32'(empty), 32'd1);
    do_op(OP_PUSH, 16'd1);
    chk("sticky/head", 32'(head), 32'd1);
    chk("sticky/valid", 32'(valid), 32'd0);
    do_reset(0);
    chk("recover/valid", 32'(valid), 32'd1);
    chk("recover/empty", 32'(empty), 32'd1);

    // Fill to capacity, then overflow
    do_reset(0);
    for (int i = 1; i <= DEPTH; i++) do_op(OP_PUSH, W'(i));
    chk("full/head", 32'(head), 32'(DEPTH));
    chk("full/valid", 32'(valid), 32'd1);
    do_op(OP_PUSH, 16'd99);
    chk("over/valid", 32'(valid), 32'd0);
    chk("over/head", 32'(head), 32'(DEPTH));
    do_op(OP_DUP, 16'd0);
    chk("dupover/head", 32'(head), 32'(DEPTH));

    // Swap, dup, add, and apply low holds state
    do_reset(0);
    do_op(OP_PUSH, 16'd4);
    do_op(OP_PUSH, 16'd9);
    do_op(OP_SWAP, 16'd0);
    chk("swap/head", 32'(head), 32'd4);
    do_op(OP_DUP, 16'd0);
    do_op(OP_ADD, 16'd0);
    chk("dupadd/head", 32'(head), 32'd8);
    idle(OP_PUSH, 16'd1234);
    chk("hold/head", 32'(head), 32'd8);

    // Reset wins over a simultaneous apply
    do_op(OP_PUSH, 16'd55);
    do_reset(1);
    chk("rstprio/empty", 32'(empty), 32'd1);

    // Randomized operation stream
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_reset($urandom_range(0, 1));
      else if (r < 10) idle(4'($urandom), W'($urandom));
      else if (r < 45) begin
        if ($urandom_range(0, 2) == 0) do_op(OP_PUSH, W'($urandom_range(0, 4)));
        else do_op(OP_PUSH, W'($urandom));
      end else do_op(4'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
